// File: rtl/cla_seq_arbiter_if.sv
// Request/response bundle for cla_seq_arbiter: two add requesters and one shared result port.
// The master modport is the requester side; the slave modport is the arbiter side.
interface cla_seq_arbiter_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         req0_valid;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_cin;
    logic         req0_ready;

    logic         req1_valid;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_cin;
    logic         req1_ready;

    logic         rsp_valid;
    logic         rsp_id;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
    logic         rsp_ovf;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );
endinterface

// File: rtl/cla_seq_arbiter.sv
// Two-requester round-robin adder that reuses one 4-bit carry-lookahead slice per nibble,
// producing one result every NIBBLES+2 cycles.
module cla_seq_arbiter #(
    parameter int NIBBLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    cla_seq_arbiter_if.slave   bus,
    output logic               busy
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [IW-1:0] r_idx;
    logic          r_carry;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_id;
    logic          r_last;
    logic [W-1:0]  r_result;
    logic [W-1:0]  r_rsp_sum;
    logic          r_rsp_cout;
    logic          r_rsp_ovf;
    logic          r_rsp_id;

    logic          w_grant;
    logic          w_ready0;
    logic          w_ready1;
    logic          w_xfer;
    logic          w_last_nib;

    logic [3:0]    w_sa;
    logic [3:0]    w_sb;
    logic [3:0]    w_g;
    logic [3:0]    w_p;
    logic [4:0]    w_c;
    logic [3:0]    w_sum;
    logic [W-1:0]  w_result_next;

    // Shared carry-lookahead slice, fed by the nibble selected by r_idx.
    assign w_sa = r_a[4*r_idx +: 4];
    assign w_sb = r_b[4*r_idx +: 4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_gp
            assign w_g[gi]   = w_sa[gi] & w_sb[gi];
            assign w_p[gi]   = w_sa[gi] ^ w_sb[gi];
            assign w_sum[gi] = w_p[gi] ^ w_c[gi];
        end
    endgenerate

    assign w_c[0] = r_carry;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

    always_comb begin
        w_result_next = r_result;
        w_result_next[4*r_idx +: 4] = w_sum;
    end

    assign w_last_nib = (r_idx == IW'(NIBBLES - 1));

    // Round robin: a lone requester always wins; on a tie the one not granted last wins.
    always_comb begin
        w_grant = 1'b0;
        if (bus.req0_valid && !bus.req1_valid) begin
            w_grant = 1'b0;
        end else if (!bus.req0_valid && bus.req1_valid) begin
            w_grant = 1'b1;
        end else if (bus.req0_valid && bus.req1_valid) begin
            w_grant = ~r_last;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready0     = 1'b0;
        w_ready1     = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready0 = bus.req0_valid && (w_grant == 1'b0);
                w_ready1 = bus.req1_valid && (w_grant == 1'b1);
                if (w_ready0 || w_ready1) begin
                    w_state_next = ADD;
                end
            end
            ADD: begin
                if (w_last_nib) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_xfer = w_ready0 | w_ready1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_id       <= 1'b0;
            r_last     <= 1'b1;
            r_result   <= '0;
            r_rsp_sum  <= '0;
            r_rsp_cout <= 1'b0;
            r_rsp_ovf  <= 1'b0;
            r_rsp_id   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_a     <= w_grant ? bus.req1_a   : bus.req0_a;
                        r_b     <= w_grant ? bus.req1_b   : bus.req0_b;
                        r_carry <= w_grant ? bus.req1_cin : bus.req0_cin;
                        r_id    <= w_grant;
                        r_last  <= w_grant;
                        r_idx   <= '0;
                    end
                end
                ADD: begin
                    r_result <= w_result_next;
                    r_carry  <= w_c[4];
                    if (w_last_nib) begin
                        // Publish on the way into DONE; held until the next completed add.
                        r_idx      <= '0;
                        r_rsp_sum  <= w_result_next;
                        r_rsp_cout <= w_c[4];
                        r_rsp_ovf  <= w_c[3] ^ w_c[4];
                        r_rsp_id   <= r_id;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.rsp_valid  = (r_state == DONE);
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_sum    = r_rsp_sum;
    assign bus.rsp_cout   = r_rsp_cout;
    assign bus.rsp_ovf    = r_rsp_ovf;
    assign busy           = (r_state != IDLE);

endmodule
